alu: RTL and testbench

Combinational 8/16-bit arithmetic-logic unit of the f8 CPU core. It takes up to three operands, an operation select, the incoming carry and the swap-operand prefix state. It returns a register-destined result, a memory-destined result and the C/Z/N condition outputs in the same cycle. A small registered status copy of the last condition outputs is kept for debug and observability.

---
 rtl/alu.sv | 144 ++++++++++++++
 tb/tb_alu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: combinational 8/16-bit arithmetic-logic unit for the f8 core.
// Results and condition outputs are combinational with zero latency. The only
// state is flags_q, a debug copy of the previous cycle's {n,z,c}.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  aluinst,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic        c_in,
  input  logic        swapop_in,
  output logic [15:0] result_reg,
  output logic [15:0] result_mem,
  output logic        c_out,
  output logic        z_out,
  output logic        n_out,
  output logic [2:0]  flags_q
);

  localparam logic [4:0] OP_SUB    = 5'd0;
  localparam logic [4:0] OP_SBC    = 5'd1;
  localparam logic [4:0] OP_ADD    = 5'd2;
  localparam logic [4:0] OP_ADC    = 5'd3;
  localparam logic [4:0] OP_OR     = 5'd4;
  localparam logic [4:0] OP_AND    = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SLL    = 5'd8;
  localparam logic [4:0] OP_RRC    = 5'd9;
  localparam logic [4:0] OP_RLC    = 5'd10;
  localparam logic [4:0] OP_INC    = 5'd11;
  localparam logic [4:0] OP_DEC    = 5'd12;
  localparam logic [4:0] OP_CLR    = 5'd13;
  localparam logic [4:0] OP_PASS0  = 5'd14;
  localparam logic [4:0] OP_SUBW   = 5'd15;
  localparam logic [4:0] OP_SBCW   = 5'd16;
  localparam logic [4:0] OP_ADDW   = 5'd17;
  localparam logic [4:0] OP_ADCW   = 5'd18;
  localparam logic [4:0] OP_ORW    = 5'd19;
  localparam logic [4:0] OP_XCHB   = 5'd20;
  localparam logic [4:0] OP_ADSW   = 5'd21;
  localparam logic [4:0] OP_SEX    = 5'd22;
  localparam logic [4:0] OP_XCHW   = 5'd23;
  localparam logic [4:0] OP_PASSW0 = 5'd24;

  logic        swap_en;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [7:0]  xchb_mem;
  logic        xchb_bit;
  logic [2:0]  flags_d;

  // Only the two-operand ALU ops honour the swap prefix; everything else reads op0/op1 directly.
  always_comb begin
    swap_en = swapop_in &&
              ((aluinst <= OP_XOR) || ((aluinst >= OP_SUBW) && (aluinst <= OP_ORW)));
    a16 = swap_en ? op1 : op0;
    b16 = swap_en ? op0 : op1;
  end

  // XCHB: select op1[i] and build op1[7:0] with bit i replaced by op0[0].
  assign xchb_bit = op1[op2[2:0]];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_xchb
      assign xchb_mem[gi] = (op2[2:0] == 3'(gi)) ? op0[0] : op1[gi];
    end
  endgenerate

  // Main datapath: byte ops produce r8, word ops r16; flags derive from whichever applies.
  always_comb begin
    logic [7:0]  r8;
    logic [15:0] r16;
    logic        is_word;
    logic        carry;
    r8      = 8'h00;
    r16     = 16'h0000;
    is_word = 1'b0;
    carry   = c_in;
    case (aluinst)
      OP_SUB:    {carry, r8} = {1'b0, a16[7:0]} + {1'b0, ~b16[7:0]} + 9'd1;
      OP_SBC:    {carry, r8} = {1'b0, a16[7:0]} + {1'b0, ~b16[7:0]} + {8'h00, c_in};
      OP_ADD:    {carry, r8} = {1'b0, a16[7:0]} + {1'b0, b16[7:0]};
      OP_ADC:    {carry, r8} = {1'b0, a16[7:0]} + {1'b0, b16[7:0]} + {8'h00, c_in};
      OP_OR:     r8 = a16[7:0] | b16[7:0];
      OP_AND:    r8 = a16[7:0] & b16[7:0];
      OP_XOR:    r8 = a16[7:0] ^ b16[7:0];
      OP_SRL:    begin r8 = {1'b0, op0[7:1]}; carry = op0[0]; end
      OP_SLL:    begin r8 = {op0[6:0], 1'b0}; carry = op0[7]; end
      OP_RRC:    begin r8 = {c_in, op0[7:1]}; carry = op0[0]; end
      OP_RLC:    begin r8 = {op0[6:0], c_in}; carry = op0[7]; end
      OP_INC:    {carry, r8} = {1'b0, op0[7:0]} + 9'd1;
      OP_DEC:    {carry, r8} = {1'b0, op0[7:0]} + 9'h0FF;
      OP_CLR:    r8 = 8'h00;
      OP_SUBW:   begin is_word = 1'b1; {carry, r16} = {1'b0, a16} + {1'b0, ~b16} + 17'd1; end
      OP_SBCW:   begin is_word = 1'b1; {carry, r16} = {1'b0, a16} + {1'b0, ~b16} + {16'h0000, c_in}; end
      OP_ADDW:   begin is_word = 1'b1; {carry, r16} = {1'b0, a16} + {1'b0, b16}; end
      OP_ADCW:   begin is_word = 1'b1; {carry, r16} = {1'b0, a16} + {1'b0, b16} + {16'h0000, c_in}; end
      OP_ORW:    begin is_word = 1'b1; r16 = a16 | b16; end
      OP_XCHB:   r8 = {op0[7:1], xchb_bit};
      OP_ADSW:   begin is_word = 1'b1; {carry, r16} = {1'b0, op0} + {1'b0, {8{op1[7]}}, op1[7:0]}; end
      OP_SEX:    begin is_word = 1'b1; r16 = {{8{op0[7]}}, op0[7:0]}; end
      // XCHW flags describe op0; the swapped result words are patched in below.
      OP_XCHW:   begin is_word = 1'b1; r16 = op0; end
      OP_PASSW0: begin is_word = 1'b1; r16 = op0; end
      // PASS0 and the unused codes 25..31
      default:   begin r8 = op0[7:0]; carry = 1'b0; end
    endcase

    c_out = carry;
    if (is_word) begin
      result_reg = r16;
      z_out      = (r16 == 16'h0000);
      n_out      = r16[15];
    end else begin
      result_reg = {8'h00, r8};
      z_out      = (r8 == 8'h00);
      n_out      = r8[7];
    end
    result_mem = result_reg;

    if (aluinst == OP_XCHB) begin
      result_mem = {8'h00, xchb_mem};
      z_out      = ~xchb_bit;
      n_out      = 1'b0;
    end
    if (aluinst == OP_XCHW) begin
      result_reg = op1;
      result_mem = op0;
    end
  end

  assign flags_d = {n_out, z_out, c_out};

  // Debug status copy of the last condition outputs; cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of the alu against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [4:0]  aluinst;
  logic [15:0] op0;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        c_in;
  logic        swapop_in;
  logic [15:0] result_reg;
  logic [15:0] result_mem;
  logic        c_out;
  logic        z_out;
  logic        n_out;
  logic [2:0]  flags_q;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk(clk), .reset(reset), .aluinst(aluinst), .op0(op0), .op1(op1), .op2(op2),
    .c_in(c_in), .swapop_in(swapop_in), .result_reg(result_reg), .result_mem(result_mem),
    .c_out(c_out), .z_out(z_out), .n_out(n_out), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic from the operation rules.
  task automatic model(input int op, input logic [15:0] x0, input logic [15:0] x1,
                       input logic [15:0] x2, input logic ci, input logic sw,
                       output logic [15:0] er, output logic [15:0] em,
                       output logic ec, output logic ez, output logic en);
    int a, b, a8, b8, r, s, ci_i, i, bit_v, m;
    bit word;
    word = 0;
    ci_i = ci ? 1 : 0;
    if (sw && ((op >= 0 && op <= 6) || (op >= 15 && op <= 19))) begin
      a = int'(x1); b = int'(x0);
    end else begin
      a = int'(x0); b = int'(x1);
    end
    a8 = a % 256;
    b8 = b % 256;
    r = 0;
    ec = ci;
    case (op)
      0:  begin s = a8 + (255 - b8) + 1;    r = s % 256; ec = (s > 255); end
      1:  begin s = a8 + (255 - b8) + ci_i; r = s % 256; ec = (s > 255); end
      2:  begin s = a8 + b8;                r = s % 256; ec = (s > 255); end
      3:  begin s = a8 + b8 + ci_i;         r = s % 256; ec = (s > 255); end
      4:  r = a8 | b8;
      5:  r = a8 & b8;
      6:  r = a8 ^ b8;
      7:  begin r = (int'(x0) % 256) / 2; ec = x0[0]; end
      8:  begin r = ((int'(x0) % 256) * 2) % 256; ec = x0[7]; end
      9:  begin r = (int'(x0) % 256) / 2 + 128 * ci_i; ec = x0[0]; end
      10: begin r = ((int'(x0) % 256) * 2) % 256 + ci_i; ec = x0[7]; end
      11: begin s = int'(x0) % 256 + 1;   r = s % 256; ec = (s > 255); end
      12: begin s = int'(x0) % 256 + 255; r = s % 256; ec = (s > 255); end
      13: r = 0;
      15: begin word = 1; s = a + (65535 - b) + 1;    r = s % 65536; ec = (s > 65535); end
      16: begin word = 1; s = a + (65535 - b) + ci_i; r = s % 65536; ec = (s > 65535); end
      17: begin word = 1; s = a + b;                  r = s % 65536; ec = (s > 65535); end
      18: begin word = 1; s = a + b + ci_i;           r = s % 65536; ec = (s > 65535); end
      19: begin word = 1; r = a | b; end
      20: r = 0;
      21: begin
            word = 1;
            s = int'(x0) + ((x1[7]) ? (65280 + int'(x1) % 256) : (int'(x1) % 256));
            r = s % 65536; ec = (s > 65535);
          end
      22: begin word = 1; r = (x0[7]) ? (65280 + int'(x0) % 256) : (int'(x0) % 256); end
      23: begin word = 1; r = int'(x0); end
      24: begin word = 1; r = int'(x0); end
      default: begin r = int'(x0) % 256; ec = 1'b0; end
    endcase
    er = 16'(r);
    ez = (r == 0);
    en = word ? (r >= 32768) : (r >= 128);
    em = er;
    if (op == 20) begin
      i = int'(x2) % 8;
      bit_v = (int'(x1) >> i) & 1;
      er = 16'(((int'(x0) % 256) / 2) * 2 + bit_v);
      m = int'(x1) % 256;
      if (x0[0]) m = m | (1 << i);
      else m = m & (255 - (1 << i));
      em = 16'(m);
      ez = (bit_v == 0);
      en = 1'b0;
      ec = ci;
    end
    if (op == 23) begin
      er = x1;
      em = x0;
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic ci, input logic sw);
    aluinst = op; op0 = a; op1 = b; op2 = c; c_in = ci; swapop_in = sw;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (flags_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_initial: flags_q=%b expected=000", flags_q);
    end
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_held: flags_q=%b expected=000", flags_q);
    end
    $display("reset: flags_q=%b", flags_q);
  endtask

  task automatic test_directed;
    drive(5'd2, 16'h00F0, 16'h0020, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg, result_mem, c_out, z_out, n_out} !== {16'h0010, 16'h0010, 3'b100}) begin
      errors++;
      $display("FAIL add_f0_20: reg=%h mem=%h c=%b z=%b n=%b expected reg=0010 mem=0010 c=1 z=0 n=0",
               result_reg, result_mem, c_out, z_out, n_out);
    end
    $display("ADD F0+20: reg=%h c=%b z=%b n=%b", result_reg, c_out, z_out, n_out);

    drive(5'd0, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg, c_out, z_out} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL sub_equal: reg=%h c=%b z=%b expected reg=0000 c=1 z=1", result_reg, c_out, z_out);
    end
    $display("SUB 05-05: reg=%h c=%b z=%b", result_reg, c_out, z_out);

    drive(5'd0, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b1); #1;
    checks++;
    if (result_reg !== 16'h0002) begin
      errors++;
      $display("FAIL sub_swap: reg=%h expected=0002", result_reg);
    end
    $display("SUB swapped 05-03: reg=%h", result_reg);

    drive(5'd9, 16'h0001, 16'h0, 16'h0, 1'b1, 1'b0); #1;
    checks++;
    if ({result_reg, c_out, n_out} !== {16'h0080, 2'b11}) begin
      errors++;
      $display("FAIL rrc: reg=%h c=%b n=%b expected reg=0080 c=1 n=1", result_reg, c_out, n_out);
    end
    $display("RRC 01 cin=1: reg=%h c=%b n=%b", result_reg, c_out, n_out);

    drive(5'd10, 16'h0080, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg, c_out, z_out} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL rlc: reg=%h c=%b z=%b expected reg=0000 c=1 z=1", result_reg, c_out, z_out);
    end
    $display("RLC 80 cin=0: reg=%h c=%b z=%b", result_reg, c_out, z_out);

    drive(5'd17, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg, c_out, z_out} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL addw_wrap: reg=%h c=%b z=%b expected reg=0000 c=1 z=1", result_reg, c_out, z_out);
    end
    $display("ADDW FFFF+1: reg=%h c=%b z=%b", result_reg, c_out, z_out);

    drive(5'd21, 16'h0100, 16'h00FE, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if (result_reg !== 16'h00FE) begin
      errors++;
      $display("FAIL adsw: reg=%h expected=00fe", result_reg);
    end
    $display("ADSW 0100+sx(FE): reg=%h", result_reg);

    drive(5'd20, 16'h0001, 16'h0000, 16'h0003, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg[0], result_mem, z_out} !== {1'b0, 16'h0008, 1'b1}) begin
      errors++;
      $display("FAIL xchb: reg=%h mem=%h z=%b expected reg[0]=0 mem=0008 z=1", result_reg, result_mem, z_out);
    end
    $display("XCHB bit3: reg=%h mem=%h z=%b", result_reg, result_mem, z_out);

    drive(5'd23, 16'hAA55, 16'h1234, 16'h0, 1'b0, 1'b0); #1;
    checks++;
    if ({result_reg, result_mem} !== {16'h1234, 16'hAA55}) begin
      errors++;
      $display("FAIL xchw: reg=%h mem=%h expected reg=1234 mem=aa55", result_reg, result_mem);
    end
    $display("XCHW: reg=%h mem=%h", result_reg, result_mem);
  endtask

  task automatic test_flags_reg;
    @(negedge clk);
    reset = 1'b0;
    drive(5'd2, 16'h00F0, 16'h0020, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 3'b001) begin
      errors++;
      $display("FAIL flags_add: flags_q=%b expected=001", flags_q);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (flags_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: flags_q=%b expected=000", flags_q);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(5'd12, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 3'b100) begin
      errors++;
      $display("FAIL flags_dec: flags_q=%b expected=100", flags_q);
    end
    $display("flags_q after DEC 00: %b", flags_q);
  endtask

  // Operands that the selected op ignores are driven to X and must not leak.
  task automatic test_unused_x;
    logic [15:0] a, b, c, er, em;
    logic ec, ez, en, ci;
    for (int op = 0; op < 25; op++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); ci = 1'($urandom);
      model(op, a, b, c, ci, 1'b0, er, em, ec, ez, en);
      aluinst = 5'(op); c_in = ci; swapop_in = 1'b0;
      op0 = a; op1 = b; op2 = (op == 20) ? {13'bx, c[2:0]} : 16'bx;
      if (!((op >= 15 && op <= 19) || op == 21 || op >= 22)) begin
        op0[15:8] = 8'bx;
        op1[15:8] = 8'bx;
      end
      if ((op >= 7 && op <= 14) || op == 22 || op == 24) op1 = 16'bx;
      #1;
      checks++;
      if ({result_reg, result_mem, c_out, z_out, n_out} !== {er, em, ec, ez, en}) begin
        errors++;
        $display("FAIL unused_x op=%0d: reg=%h mem=%h czn=%b%b%b expected reg=%h mem=%h czn=%b%b%b",
                 op, result_reg, result_mem, c_out, z_out, n_out, er, em, ec, ez, en);
      end
    end
    $display("unused-operand isolation: 25 ops checked");
  endtask

  task automatic test_random;
    logic [15:0] a, b, c, er, em;
    logic ec, ez, en, ci, sw;
    int op;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      op = int'($urandom_range(0, 31));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      ci = 1'($urandom); sw = 1'($urandom);
      if (t % 16 == 0) b = a;
      drive(5'(op), a, b, c, ci, sw);
      model(op, a, b, c, ci, sw, er, em, ec, ez, en);
      #1;
      checks++;
      if ({result_reg, result_mem, c_out, z_out, n_out} !== {er, em, ec, ez, en}) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h i=%0d ci=%b sw=%b: reg=%h mem=%h czn=%b%b%b expected reg=%h mem=%h czn=%b%b%b",
                 op, a, b, c[2:0], ci, sw, result_reg, result_mem, c_out, z_out, n_out, er, em, ec, ez, en);
      end
      @(posedge clk); #1;
      checks++;
      if (flags_q !== {en, ez, ec}) begin
        errors++;
        $display("FAIL random_flags_q op=%0d: flags_q=%b expected=%b", op, flags_q, {en, ez, ec});
      end
      $display("txn %0d: op=%0d a=%h b=%h reg=%h mem=%h flags_q=%b", t, op, a, b, result_reg, result_mem, flags_q);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(5'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    test_reset;
    test_directed;
    test_flags_reg;
    test_unused_x;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
